note_freq_gen_x64: RTL and testbench
====================================

Name: note_freq_gen_x64

Overview:
- Converts a 6-bit note index into a square clock-enable-style signal at 64× the note's musical pitch.
- Driven from the 50 MHz system clock.
- Feeds the 64-step square/triangle waveform generators through a global clock buffer.
- One instance per synthesizer channel; the note input may come directly from the sequencer or from the portamento FX mux.

Parameters:
- CNT_W, 14, width of the half-period divider counter (must hold 5972).
- NOTE_W, 6, width of the note index input.

Ports:
- clk50mhz  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- note_in  input  NOTE_W  note index. 0 = silence; 1..63 = chromatic semitones, note 1 = C2 (65.406 Hz).
- freq_out  output  1  50%-duty square wave at 64 × f(note_in).

Behaviour:
- Pitch: f(n) = 65.406 Hz × 2^((n−1)/12) for n = 1..63.
  - Notes 1, 13, 25, 37, 49 are C2..C6.
  - Note 46 = A5 = 880 Hz.
- Divider ROM: a combinational 64-entry lookup gives D(n) = round(50e6 / (128 × f(n))), the half-period in clk50mhz cycles.
  - Required entries: D(1)=5972, D(13)=2986, D(25)=1493, D(37)=747, D(46)=444, D(49)=373, D(63)=166.
  - D(0) is unused.
  - All entries are computed offline and hard-coded as unsigned CNT_W-bit constants.
- State: counter cnt (CNT_W bits) and output register freq_out.
- Reset: rst_n low asynchronously forces cnt=0 and freq_out=0, independent of clk50mhz.
- Each rising clk50mhz edge, with rst_n high:
  - note_in==0: cnt←0, freq_out←0 (silence, output parked low).
  - else if cnt ≥ D(note_in)−1: cnt←0, freq_out←~freq_out.
  - else: cnt←cnt+1.
- Timing:
  - Period of freq_out = 2·D(n) clock cycles.
  - The first rising edge of freq_out occurs on the D(n)-th clock edge after reset release, or after leaving silence.
- Note change (default build):
  - The new D applies on the very next edge.
  - The ≥ comparison guarantees that a counter already past the new terminal count wraps on the next edge and toggles once. It never runs up to 2^CNT_W.
- freq_out is a registered output with no combinational path from note_in.
- The note_in value is sampled every cycle. It is not latched.
- Reset asserted mid-period discards the phase. Counting restarts from 0 after release.

Optional Feature:
- Macro FREQGEN_PHASE_CONT_EN.
- When defined:
  - A D_active register (CNT_W bits, reset to D(1)) holds the divider in use.
  - Comparisons use D_active.
  - D_active loads D(note_in) only on a wrap edge (the edge where freq_out toggles), or on the edge leaving silence. This gives phase-continuous pitch changes: the half-period in progress always completes with the old divider.
  - Silence (note 0) still forces cnt=0 and freq_out=0 immediately.
- When not defined: the immediate-apply behaviour above.

Test Plan:
- Reset: hold rst_n=0 with note_in=37 and clock running, then deassert → freq_out stays 0. First rise occurs at edge 747 after release; period is 1494 cycles; high and low are each 747 cycles.
- Async reset: mid-period, assert rst_n low between clock edges → freq_out=0 and cnt=0 immediately without a clock edge. After release, behaviour matches a fresh start.
- Pitch sweep: notes 1, 13, 25, 46, 63 each held for ≥3 periods → measured half-periods are 5972, 2986, 1493, 444, 166 cycles respectively.
- Silence: note_in=0 mid-period → freq_out=0 on the next edge and stays 0. Changing to note 49 → first rise 373 edges later.
- Downward divider change (default build): note 1 with cnt≈3000, then switch to note 63 → toggle on the next edge, then 166-cycle half-periods.
- With FREQGEN_PHASE_CONT_EN: note 25 → 37 switch mid-half-period → the current half-period completes at 1493 cycles, subsequent half-periods are 747 cycles. There is no early toggle.

Source files
------------

// File: rtl/note_freq_gen_x64.sv
// Note index to square wave at 64x musical pitch, divided from the 50 MHz clock.
// Optional FREQGEN_PHASE_CONT_EN: divider changes take effect only at a half-period boundary.
module note_freq_gen_x64 #(
  parameter int CNT_W  = 14,
  parameter int NOTE_W = 6
) (
  input  logic              clk50mhz,
  input  logic              rst_n,
  input  logic [NOTE_W-1:0] note_in,
  output logic              freq_out
);

  // Half-period in clk50mhz cycles: round(50e6 / (128 * 65.406 * 2^((n-1)/12)))
  function automatic int div_rom(input int n);
    case (n)
       1: return 5972;  2: return 5637;  3: return 5321;  4: return 5022;
       5: return 4740;  6: return 4474;  7: return 4223;  8: return 3986;
       9: return 3762; 10: return 3551; 11: return 3352; 12: return 3164;
      13: return 2986; 14: return 2819; 15: return 2660; 16: return 2511;
      17: return 2370; 18: return 2237; 19: return 2112; 20: return 1993;
      21: return 1881; 22: return 1776; 23: return 1676; 24: return 1582;
      25: return 1493; 26: return 1409; 27: return 1330; 28: return 1256;
      29: return 1185; 30: return 1119; 31: return 1056; 32: return  997;
      33: return  941; 34: return  888; 35: return  838; 36: return  791;
      37: return  747; 38: return  705; 39: return  665; 40: return  628;
      41: return  593; 42: return  559; 43: return  528; 44: return  498;
      45: return  470; 46: return  444; 47: return  419; 48: return  395;
      49: return  373; 50: return  352; 51: return  333; 52: return  314;
      53: return  296; 54: return  280; 55: return  264; 56: return  249;
      57: return  235; 58: return  222; 59: return  209; 60: return  198;
      61: return  187; 62: return  176; 63: return  166;
      default: return 0;
    endcase
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             freq_out_q, freq_out_d;
  logic [CNT_W-1:0] d_sel, d_use;
  logic             silent, wrap;

  assign d_sel    = CNT_W'(div_rom(int'(note_in)));
  assign silent   = (note_in == '0);
  assign freq_out = freq_out_q;

`ifdef FREQGEN_PHASE_CONT_EN
  logic [CNT_W-1:0] d_active_q, d_active_d;
  logic             silent_q, silent_d;

  assign d_use = d_active_q;

  // Reload only at a wrap or on the first edge out of silence, so a half-period never gets cut short.
  always_comb begin
    d_active_d = d_active_q;
    silent_d   = silent;
    if (!silent && (wrap || silent_q)) d_active_d = d_sel;
  end

  always_ff @(posedge clk50mhz or negedge rst_n) begin
    if (!rst_n) begin
      d_active_q <= CNT_W'(div_rom(1));
      silent_q   <= 1'b0;
    end else begin
      d_active_q <= d_active_d;
      silent_q   <= silent_d;
    end
  end
`else
  assign d_use = d_sel;
`endif

  // >= rather than == so a counter already beyond a smaller new divider wraps at once.
  assign wrap = (cnt_q >= d_use - CNT_W'(1));

  always_comb begin
    cnt_d      = cnt_q;
    freq_out_d = freq_out_q;
    if (silent) begin
      cnt_d      = '0;
      freq_out_d = 1'b0;
    end else if (wrap) begin
      cnt_d      = '0;
      freq_out_d = ~freq_out_q;
    end else begin
      cnt_d      = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk50mhz or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      freq_out_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      freq_out_q <= freq_out_d;
    end
  end

endmodule

// File: tb/tb_note_freq_gen_x64.sv
// Scoreboard bench: stimulus queues expected freq_out edges (cycle, level); a monitor checks each edge seen.
module tb_note_freq_gen_x64;

  logic       clk50mhz = 1'b0;
  logic       rst_n    = 1'b0;
  logic [5:0] note_in  = 6'd37;
  logic       freq_out;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    int   c;
    logic v;
  } exp_t;
  exp_t exp_q[$];

  note_freq_gen_x64 #(.CNT_W(14), .NOTE_W(6)) dut (
    .clk50mhz (clk50mhz),
    .rst_n    (rst_n),
    .note_in  (note_in),
    .freq_out (freq_out)
  );

  always #10 clk50mhz = ~clk50mhz;
  always @(posedge clk50mhz) cyc <= cyc + 1;

  // Monitor: every observed output edge must match the head of the expected queue.
  logic prev = 1'b0;
  always @(negedge clk50mhz) begin
    if (!rst_n) prev = freq_out;
    else if (freq_out !== prev) begin
      prev = freq_out;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL edge_unexpected cyc=%0d got=%b required=no edge", cyc, freq_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.c != cyc || e.v !== freq_out) begin
          n_err++;
          $display("FAIL edge got cyc=%0d lvl=%b required cyc=%0d lvl=%b", cyc, freq_out, e.c, e.v);
        end
      end
    end
  end

  task automatic chk(input string name, input logic got, input logic req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s got=%b required=%b", name, got, req);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk50mhz);
      #2;
    end
  endtask

  task automatic push_edges(input int b, input int d, input int halves);
    for (int k = 1; k <= halves; k++) begin
      exp_t e;
      e.c = b + k * d;
      e.v = (k % 2 == 1);
      exp_q.push_back(e);
    end
  endtask

  // Start from cnt=0, freq_out=0 and run an even number of half-periods.
  task automatic run_note(input logic [5:0] note, input int d, input int halves);
    int b;
    b = cyc;
    note_in = note;
    push_edges(b, d, halves);
    wait_until(b + halves * d);
  endtask

  initial begin
    int b;
    int s;
    exp_t e;

    // Reset held with clock running and note 37
    repeat (5) begin @(posedge clk50mhz); #2; end
    chk("reset_low", freq_out, 1'b0);
    rst_n = 1'b1;
    b = cyc;
    push_edges(b, 747, 3);
    wait_until(b + 2);
    chk("after_release", freq_out, 1'b0);
    wait_until(b + 3 * 747 + 300);
    chk("high_before_async", freq_out, 1'b1);

    // Async reset between edges
    rst_n = 1'b0;
    #1;
    chk("async_reset_immediate", freq_out, 1'b0);
    @(posedge clk50mhz); #2;
    @(posedge clk50mhz); #2;
    chk("async_reset_held", freq_out, 1'b0);
    rst_n = 1'b1;
    run_note(6'd37, 747, 2);

    // Pitch sweep
    run_note(6'd1,  5972, 4);
    run_note(6'd13, 2986, 4);
    run_note(6'd25, 1493, 4);
    run_note(6'd46,  444, 4);
    run_note(6'd63,  166, 4);

    // Silence mid-period, then note 49
    b = cyc;
    note_in = 6'd25;
    push_edges(b, 1493, 1);
    wait_until(b + 1493 + 200);
    chk("high_before_silence", freq_out, 1'b1);
    note_in = 6'd0;
    s = cyc;
    e.c = s + 1;
    e.v = 1'b0;
    exp_q.push_back(e);
    wait_until(s + 1);
    chk("silence_next_edge", freq_out, 1'b0);
    wait_until(s + 50);
    chk("silence_held", freq_out, 1'b0);
    run_note(6'd49, 373, 2);

    // Downward divider change with counter near 3000
    b = cyc;
    note_in = 6'd1;
    wait_until(b + 3000);
    chk("low_before_downshift", freq_out, 1'b0);
    note_in = 6'd63;
    push_edges(b + 3001 - 166, 166, 5);
    wait_until(b + 3001 + 4 * 166 + 10);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL edges_missing got=%0d outstanding required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
